// File: rtl/pe_stop_launch.sv
// pe_stop_launch: queues OOB option pointers, fetches each stOp descriptor from the
// configuration ROM, issues it to the streaming-op controller and reports retirement.
module pe_stop_launch #(
    parameter int PTR_W    = 8,
    parameter int OP_W     = 8,
    parameter int ADDR_W   = 24,
    parameter int TYPE_W   = 2,
    parameter int NOPS_W   = 12,
    parameter int ROM_WAIT = 1
) (
    input  logic              clk,
    input  logic              reset_poweron,

    input  logic              cntl__launch__ptr_valid,
    input  logic [PTR_W-1:0]  cntl__launch__ptr,
    output logic              launch__cntl__ptr_ready,

    output logic [PTR_W-1:0]  launch__rom__optionPtr,
    input  logic [OP_W-1:0]   rom__launch__stOp_operation,
    input  logic [ADDR_W-1:0] rom__launch__sourceAddress0,
    input  logic [ADDR_W-1:0] rom__launch__sourceAddress1,
    input  logic [ADDR_W-1:0] rom__launch__destinationAddress0,
    input  logic [ADDR_W-1:0] rom__launch__destinationAddress1,
    input  logic [TYPE_W-1:0] rom__launch__src_data_type0,
    input  logic [TYPE_W-1:0] rom__launch__src_data_type1,
    input  logic [TYPE_W-1:0] rom__launch__dest_data_type0,
    input  logic [TYPE_W-1:0] rom__launch__dest_data_type1,
    input  logic [NOPS_W-1:0] rom__launch__numberOfOperands,

    output logic              launch__stOp__valid,
    input  logic              stOp__launch__ready,
    output logic [OP_W-1:0]   launch__stOp__stOp_operation,
    output logic [ADDR_W-1:0] launch__stOp__sourceAddress0,
    output logic [ADDR_W-1:0] launch__stOp__sourceAddress1,
    output logic [ADDR_W-1:0] launch__stOp__destinationAddress0,
    output logic [ADDR_W-1:0] launch__stOp__destinationAddress1,
    output logic [TYPE_W-1:0] launch__stOp__src_data_type0,
    output logic [TYPE_W-1:0] launch__stOp__src_data_type1,
    output logic [TYPE_W-1:0] launch__stOp__dest_data_type0,
    output logic [TYPE_W-1:0] launch__stOp__dest_data_type1,
    output logic [NOPS_W-1:0] launch__stOp__numberOfOperands,

    input  logic              stOp__launch__complete0,
    input  logic              stOp__launch__complete1,
    output logic              launch__cntl__done,
    output logic              launch__cntl__error,
    output logic              launch__cntl__busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int CNT_W = (ROM_WAIT > 1) ? $clog2(ROM_WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROM_WAIT - 1);

    logic [2:0]             state_q, state_d;
    logic [1:0][PTR_W-1:0]  fifo_mem_q, fifo_mem_d;
    logic                   fifo_rd_q, fifo_rd_d;
    logic                   fifo_wr_q, fifo_wr_d;
    logic [1:0]             fifo_cnt_q, fifo_cnt_d;
    logic [CNT_W-1:0]       wait_cnt_q, wait_cnt_d;
    logic [PTR_W-1:0]       option_ptr_q, option_ptr_d;
    logic [OP_W-1:0]        op_q, op_d;
    logic [ADDR_W-1:0]      src0_q, src0_d, src1_q, src1_d;
    logic [ADDR_W-1:0]      dst0_q, dst0_d, dst1_q, dst1_d;
    logic [TYPE_W-1:0]      st0_q, st0_d, st1_q, st1_d;
    logic [TYPE_W-1:0]      dt0_q, dt0_d, dt1_q, dt1_d;
    logic [NOPS_W-1:0]      nops_q, nops_d;
    logic                   flag0_q, flag0_d, flag1_q, flag1_d;
    logic                   error_q, error_d;
    logic                   push, pop, fifo_empty, ptr_ready;

    assign ptr_ready  = (fifo_cnt_q < 2'd2);
    assign fifo_empty = (fifo_cnt_q == 2'd0);
    assign push       = cntl__launch__ptr_valid && ptr_ready;

    always_comb begin
        state_d      = state_q;
        fifo_mem_d   = fifo_mem_q;
        fifo_rd_d    = fifo_rd_q;
        fifo_wr_d    = fifo_wr_q;
        fifo_cnt_d   = fifo_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        option_ptr_d = option_ptr_q;
        op_d         = op_q;
        src0_d       = src0_q;
        src1_d       = src1_q;
        dst0_d       = dst0_q;
        dst1_d       = dst1_q;
        st0_d        = st0_q;
        st1_d        = st1_q;
        dt0_d        = dt0_q;
        dt1_d        = dt1_q;
        nops_d       = nops_q;
        flag0_d      = flag0_q;
        flag1_d      = flag1_q;
        error_d      = error_q;
        pop          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (wait_cnt_q == CNT_LAST) begin
                    op_d   = rom__launch__stOp_operation;
                    src0_d = rom__launch__sourceAddress0;
                    src1_d = rom__launch__sourceAddress1;
                    dst0_d = rom__launch__destinationAddress0;
                    dst1_d = rom__launch__destinationAddress1;
                    st0_d  = rom__launch__src_data_type0;
                    st1_d  = rom__launch__src_data_type1;
                    dt0_d  = rom__launch__dest_data_type0;
                    dt1_d  = rom__launch__dest_data_type1;
                    nops_d = rom__launch__numberOfOperands;
                    // An empty operation is never issued; it retires straight away.
                    if (rom__launch__numberOfOperands == '0) begin
                        error_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            S_ISSUE: begin
                if (stOp__launch__ready) begin
                    flag0_d = 1'b0;
                    flag1_d = 1'b0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flag0_q && flag1_q) begin
                    state_d = S_DONE;
                end else begin
                    flag0_d = flag0_q | stOp__launch__complete0;
                    flag1_d = flag1_q | stOp__launch__complete1;
                end
            end
            S_DONE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (pop) begin
            option_ptr_d = fifo_mem_q[fifo_rd_q];
            wait_cnt_d   = '0;
            fifo_rd_d    = ~fifo_rd_q;
        end
        if (push) begin
            fifo_mem_d[fifo_wr_q] = cntl__launch__ptr;
            fifo_wr_d             = ~fifo_wr_q;
        end
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            state_q      <= S_IDLE;
            fifo_mem_q   <= '0;
            fifo_rd_q    <= 1'b0;
            fifo_wr_q    <= 1'b0;
            fifo_cnt_q   <= 2'd0;
            wait_cnt_q   <= '0;
            option_ptr_q <= '0;
            op_q         <= '0;
            src0_q       <= '0;
            src1_q       <= '0;
            dst0_q       <= '0;
            dst1_q       <= '0;
            st0_q        <= '0;
            st1_q        <= '0;
            dt0_q        <= '0;
            dt1_q        <= '0;
            nops_q       <= '0;
            flag0_q      <= 1'b0;
            flag1_q      <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            fifo_mem_q   <= fifo_mem_d;
            fifo_rd_q    <= fifo_rd_d;
            fifo_wr_q    <= fifo_wr_d;
            fifo_cnt_q   <= fifo_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            option_ptr_q <= option_ptr_d;
            op_q         <= op_d;
            src0_q       <= src0_d;
            src1_q       <= src1_d;
            dst0_q       <= dst0_d;
            dst1_q       <= dst1_d;
            st0_q        <= st0_d;
            st1_q        <= st1_d;
            dt0_q        <= dt0_d;
            dt1_q        <= dt1_d;
            nops_q       <= nops_d;
            flag0_q      <= flag0_d;
            flag1_q      <= flag1_d;
            error_q      <= error_d;
        end
    end

    assign launch__cntl__ptr_ready           = ptr_ready;
    assign launch__rom__optionPtr            = option_ptr_q;
    assign launch__stOp__valid               = (state_q == S_ISSUE);
    assign launch__stOp__stOp_operation      = op_q;
    assign launch__stOp__sourceAddress0      = src0_q;
    assign launch__stOp__sourceAddress1      = src1_q;
    assign launch__stOp__destinationAddress0 = dst0_q;
    assign launch__stOp__destinationAddress1 = dst1_q;
    assign launch__stOp__src_data_type0      = st0_q;
    assign launch__stOp__src_data_type1      = st1_q;
    assign launch__stOp__dest_data_type0     = dt0_q;
    assign launch__stOp__dest_data_type1     = dt1_q;
    assign launch__stOp__numberOfOperands    = nops_q;
    assign launch__cntl__done                = (state_q == S_DONE);
    assign launch__cntl__error               = error_q;
    assign launch__cntl__busy                = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_pe_stop_launch.sv
// Bench for pe_stop_launch: directed scenarios then random traffic, scored against an
// in-order model of accepted pointers, ROM contents and lane-completion rules.
module tb_pe_stop_launch;

    typedef struct packed {
        logic [7:0]  op;
        logic [23:0] s0;
        logic [23:0] s1;
        logic [23:0] d0;
        logic [23:0] d1;
        logic [1:0]  st0;
        logic [1:0]  st1;
        logic [1:0]  dt0;
        logic [1:0]  dt1;
        logic [11:0] nops;
    } desc_t;

    logic        clk;
    logic        resetPoweron;
    logic        ptrValid;
    logic [7:0]  ptrIn;
    logic        ptrReady;
    logic [7:0]  romPtr;
    desc_t       romOut;
    logic        stValid;
    logic        stReady;
    logic [7:0]  outOp;
    logic [23:0] outS0, outS1, outD0, outD1;
    logic [1:0]  outSt0, outSt1, outDt0, outDt1;
    logic [11:0] outNops;
    desc_t       outDesc;
    logic        complete0, complete1;
    logic        doneOut, errorOut, busyOut;

    int          total = 0;
    int          bad = 0;
    int          cycleCount = 0;
    int          hsCount = 0;
    int          doneCount = 0;
    int          hsCycle = 0;
    int          bothCycle = -1;
    logic        opIssued = 1'b0;
    logic        c0Seen = 1'b0;
    logic        c1Seen = 1'b0;
    logic        errExp = 1'b0;
    logic        zeroAccepted = 1'b0;
    logic        monitorOn = 1'b0;
    logic [7:0]  issueQ[$];
    logic [7:0]  retireQ[$];
    logic        obsValid, obsPtrReady, obsDone, obsError, obsBusy;
    logic [7:0]  obsOptPtr;
    logic [11:0] obsNops;

    pe_stop_launch #(
        .PTR_W(8), .OP_W(8), .ADDR_W(24), .TYPE_W(2), .NOPS_W(12), .ROM_WAIT(1)
    ) dut (
        .clk                               (clk),
        .reset_poweron                     (resetPoweron),
        .cntl__launch__ptr_valid           (ptrValid),
        .cntl__launch__ptr                 (ptrIn),
        .launch__cntl__ptr_ready           (ptrReady),
        .launch__rom__optionPtr            (romPtr),
        .rom__launch__stOp_operation       (romOut.op),
        .rom__launch__sourceAddress0       (romOut.s0),
        .rom__launch__sourceAddress1       (romOut.s1),
        .rom__launch__destinationAddress0  (romOut.d0),
        .rom__launch__destinationAddress1  (romOut.d1),
        .rom__launch__src_data_type0       (romOut.st0),
        .rom__launch__src_data_type1       (romOut.st1),
        .rom__launch__dest_data_type0      (romOut.dt0),
        .rom__launch__dest_data_type1      (romOut.dt1),
        .rom__launch__numberOfOperands     (romOut.nops),
        .launch__stOp__valid               (stValid),
        .stOp__launch__ready               (stReady),
        .launch__stOp__stOp_operation      (outOp),
        .launch__stOp__sourceAddress0      (outS0),
        .launch__stOp__sourceAddress1      (outS1),
        .launch__stOp__destinationAddress0 (outD0),
        .launch__stOp__destinationAddress1 (outD1),
        .launch__stOp__src_data_type0      (outSt0),
        .launch__stOp__src_data_type1      (outSt1),
        .launch__stOp__dest_data_type0     (outDt0),
        .launch__stOp__dest_data_type1     (outDt1),
        .launch__stOp__numberOfOperands    (outNops),
        .stOp__launch__complete0           (complete0),
        .stOp__launch__complete1           (complete1),
        .launch__cntl__done                (doneOut),
        .launch__cntl__error               (errorOut),
        .launch__cntl__busy                (busyOut)
    );

    assign outDesc = {outOp, outS0, outS1, outD0, outD1, outSt0, outSt1, outDt0, outDt1, outNops};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents: entry 5 is op 0x11 with 16 operands, low nibble 7 means zero operands.
    function automatic desc_t romEntry(input logic [7:0] p);
        desc_t e;
        e.op  = (p == 8'h05) ? 8'h11 : (p ^ 8'h5A);
        e.s0  = {p, 16'h1000};
        e.s1  = {~p, 16'h2002};
        e.d0  = {8'hA0, p, p};
        e.d1  = {p, 8'h3C, ~p};
        e.st0 = p[1:0];
        e.st1 = p[3:2];
        e.dt0 = p[5:4];
        e.dt1 = p[7:6];
        if (p == 8'h05)           e.nops = 12'd16;
        else if (p[3:0] == 4'h7)  e.nops = 12'd0;
        else                      e.nops = {4'h0, p} + 12'd3;
        return e;
    endfunction

    always_comb romOut = romEntry(romPtr);

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clearModel();
        issueQ.delete();
        retireQ.delete();
        opIssued     = 1'b0;
        bothCycle    = -1;
        errExp       = 1'b0;
        zeroAccepted = 1'b0;
    endtask

    task automatic monitorCycle();
        logic [7:0] head;
        logic       expDoneNow;
        cycleCount++;
        obsValid    = stValid;
        obsPtrReady = ptrReady;
        obsDone     = doneOut;
        obsError    = errorOut;
        obsBusy     = busyOut;
        obsOptPtr   = romPtr;
        obsNops     = outNops;
        if (!monitorOn) return;

        checkOutput("busy", obsBusy, retireQ.size() != 0);
        if (opIssued) checkOutput("validWhileOutstanding", obsValid, 1'b0);

        if (obsValid && !opIssued) begin
            if (issueQ.size() == 0) begin
                checkOutput("unexpectedValid", obsValid, 1'b0);
            end else begin
                checkOutput("descriptor", outDesc, romEntry(issueQ[0]));
                checkOutput("optionPtr", obsOptPtr, issueQ[0]);
                if (stReady) begin
                    void'(issueQ.pop_front());
                    opIssued  = 1'b1;
                    hsCycle   = cycleCount;
                    c0Seen    = 1'b0;
                    c1Seen    = 1'b0;
                    bothCycle = -1;
                    hsCount++;
                end
            end
        end

        if (opIssued && cycleCount > hsCycle) begin
            if (complete0) c0Seen = 1'b1;
            if (complete1) c1Seen = 1'b1;
            if (c0Seen && c1Seen && bothCycle < 0) bothCycle = cycleCount;
        end

        expDoneNow = opIssued && (bothCycle >= 0) && (cycleCount == bothCycle + 2);
        if (opIssued) checkOutput("doneTiming", obsDone, expDoneNow);
        if (obsDone) begin
            doneCount++;
            if (retireQ.size() == 0) begin
                checkOutput("doneSpurious", obsDone, 1'b0);
            end else begin
                head = retireQ.pop_front();
                checkOutput("donePtr", obsOptPtr, head);
                if (opIssued) begin
                    opIssued  = 1'b0;
                    bothCycle = -1;
                end else begin
                    checkOutput("doneZeroNops", obsNops, 12'd0);
                    errExp = 1'b1;
                end
            end
        end

        if (errExp)             checkOutput("errorSticky", obsError, 1'b1);
        else if (!zeroAccepted) checkOutput("errorClear", obsError, 1'b0);

        if (ptrValid && obsPtrReady) begin
            retireQ.push_back(ptrIn);
            if (romEntry(ptrIn).nops != 12'd0) issueQ.push_back(ptrIn);
            else                               zeroAccepted = 1'b1;
        end
    endtask

    // Called at a falling edge: drive inputs, sample just after, then wait one full cycle.
    task automatic applyStimulus(input logic v, input logic [7:0] p, input logic r,
                                 input logic c0, input logic c1);
        ptrValid  = v;
        ptrIn     = p;
        stReady   = r;
        complete0 = c0;
        complete1 = c1;
        #1;
        monitorCycle();
        @(negedge clk);
    endtask

    task automatic waitValid(input logic rdy, output int vCycle);
        vCycle = -1;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 8'h00, rdy, 1'b0, 1'b0);
            if (obsValid) begin
                vCycle = cycleCount;
                break;
            end
        end
        if (vCycle < 0) checkOutput("waitValid", obsValid, 1'b1);
    endtask

    task automatic drainAll();
        for (int i = 0; i < 400; i++) begin
            if (retireQ.size() == 0) break;
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        end
        checkOutput("drainTimeout", retireQ.size(), 0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ptrReady"}, ptrReady, 1'b1);
        checkOutput({tag, "_optionPtr"}, romPtr, 8'h00);
        checkOutput({tag, "_desc"}, outDesc, '0);
        checkOutput({tag, "_valid"}, stValid, 1'b0);
        checkOutput({tag, "_done"}, doneOut, 1'b0);
        checkOutput({tag, "_error"}, errorOut, 1'b0);
        checkOutput({tag, "_busy"}, busyOut, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int nAcc, vCyc, d0, h0;
        resetPoweron = 1'b0;
        ptrValid     = 1'b0;
        ptrIn        = 8'h00;
        stReady      = 1'b0;
        complete0    = 1'b0;
        complete1    = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkResetOutputs("rstHold");
        resetPoweron = 1'b1;
        monitorOn    = 1'b1;
        @(negedge clk);
        checkResetOutputs("rstRelease");

        $display("[TB] single pointer 0x05");
        d0 = doneCount;
        applyStimulus(1'b1, 8'h05, 1'b1, 1'b0, 1'b0);
        nAcc = cycleCount;
        waitValid(1'b1, vCyc);
        checkOutput("validLatency", vCyc, nAcc + 3);
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("singleDoneCount", doneCount - d0, 1);
        checkOutput("singleBusyLow", obsBusy, 1'b0);

        $display("[TB] backpressure");
        applyStimulus(1'b1, 8'h20, 1'b0, 1'b0, 1'b0);
        waitValid(1'b0, vCyc);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            checkOutput("bpValidHeld", obsValid, 1'b1);
        end
        h0 = hsCount;
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("bpValidDrop", obsValid, 1'b0);
        checkOutput("bpSingleHandshake", hsCount - h0, 1);
        drainAll();

        $display("[TB] queue full");
        h0 = hsCount;
        applyStimulus(1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
        waitValid(1'b0, vCyc);
        applyStimulus(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
        checkOutput("qfReady1", obsPtrReady, 1'b1);
        applyStimulus(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
        checkOutput("qfReady2", obsPtrReady, 1'b1);
        applyStimulus(1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
        checkOutput("qfReady3", obsPtrReady, 1'b0);
        drainAll();
        checkOutput("qfLaunches", hsCount - h0, 3);

        $display("[TB] completion ordering");
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        d0 = doneCount;
        applyStimulus(1'b1, 8'h30, 1'b1, 1'b0, 1'b0);
        waitValid(1'b1, vCyc);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        repeat (2) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("ordNoEarlyDone", doneCount - d0, 0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("ordDoneFirst", doneCount - d0, 1);
        applyStimulus(1'b1, 8'h31, 1'b1, 1'b0, 1'b0);
        waitValid(1'b1, vCyc);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("ordDoneSecond", doneCount - d0, 2);

        $display("[TB] zero operands");
        d0 = doneCount;
        h0 = hsCount;
        applyStimulus(1'b1, 8'h07, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h08, 1'b1, 1'b0, 1'b0);
        drainAll();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("zeroHandshakes", hsCount - h0, 1);
        checkOutput("zeroDones", doneCount - d0, 2);
        checkOutput("zeroErrorSet", obsError, 1'b1);

        $display("[TB] reset during issue");
        applyStimulus(1'b1, 8'h40, 1'b0, 1'b0, 1'b0);
        waitValid(1'b0, vCyc);
        applyStimulus(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
        #2;
        resetPoweron = 1'b0;
        #1;
        checkOutput("rstValidDrop", stValid, 1'b0);
        monitorOn = 1'b0;
        clearModel();
        ptrValid  = 1'b0;
        stReady   = 1'b0;
        repeat (2) @(negedge clk);
        resetPoweron = 1'b1;
        #1;
        checkResetOutputs("rstMid");
        monitorOn = 1'b1;
        h0 = hsCount;
        repeat (10) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("rstNoLaunch", hsCount - h0, 0);
        checkOutput("rstStillIdle", obsBusy, 1'b0);

        $display("[TB] random traffic");
        for (int i = 0; i < 1500; i++) begin
            applyStimulus($urandom_range(0, 2) == 0, 8'($urandom_range(0, 255)),
                          1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                          $urandom_range(0, 3) == 0);
        end
        drainAll();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("randomIdle", obsBusy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pe_stop_launch.md
# pe_stop_launch

Sequencer between the PE OOB control decode and the streaming-op controller. It queues streamingOp option pointers decoded from OOB {option,data} tuples and drives each pointer into the stOp configuration ROM. After the ROM settles it registers the full operation descriptor and hands it to the streaming-op controller over a valid/ready handshake. It then waits for both lanes to report completion and signals done back to control, so a new option never disturbs an operation in flight.

## Interface
- PTR_W, 8, option pointer width
- OP_W, 8, stOp operation code width
- ADDR_W, 24, chiplet address width
- TYPE_W, 2, data-type field width
- NOPS_W, 12, numberOfOperands width
- ROM_WAIT, 1, cycles the pointer is held before descriptor capture (≥1)
- clk  in  1  clock, all logic on rising edge
- reset_poweron  in  1  asynchronous, active-low reset
- cntl__launch__ptr_valid  in  1  option pointer offered
- cntl__launch__ptr  in  PTR_W  option pointer
- launch__cntl__ptr_ready  out  1  pointer queue not full
- launch__rom__optionPtr  out  PTR_W  registered pointer to stOp ROM
- rom__launch__stOp_operation  in  OP_W  ROM operation
- rom__launch__sourceAddress0/1, rom__launch__destinationAddress0/1  in  ADDR_W each  ROM lane addresses
- rom__launch__src_data_type0/1, rom__launch__dest_data_type0/1  in  TYPE_W each  ROM lane types
- rom__launch__numberOfOperands  in  NOPS_W  ROM operand count
- launch__stOp__valid  out  1  descriptor valid
- stOp__launch__ready  in  1  controller accepts descriptor
- launch__stOp__* (same ten fields, same widths)  out  registered descriptor
- stOp__launch__complete0, stOp__launch__complete1  in  1 each  lane-done pulses
- launch__cntl__done  out  1  one-cycle pulse per retired pointer
- launch__cntl__error  out  1  sticky: zero-operand descriptor seen
- launch__cntl__busy  out  1  state≠IDLE or queue non-empty

## Operation
- 2-entry pointer FIFO. Push on ptr_valid && ptr_ready. ptr_ready = (count<2), combinational from count. A push and a pop in the same cycle are legal at count 1. When count is 2, ptr_ready=0 and the offered pointer is not taken.
- FSM states: IDLE, FETCH, ISSUE, WAIT, DONE.
- IDLE with FIFO non-empty: pop the FIFO, load launch__rom__optionPtr, go to FETCH.
- FETCH: hold for ROM_WAIT cycles (counter). On the last cycle, register all ten ROM fields into the launch__stOp__* outputs.
  - If the captured numberOfOperands ≠ 0, go to ISSUE.
  - If it is 0, set error and go to DONE without issuing.
- ISSUE: launch__stOp__valid=1, descriptor held stable until valid && ready. Then go to WAIT and clear the lane-complete flags.
- WAIT: latch complete0 and complete1 into flags, in any order, including both in the same cycle. Go to DONE in the cycle after both flags are set.
- DONE: launch__cntl__done=1 for exactly one cycle. Then go to FETCH directly if the FIFO is non-empty (popping in DONE), otherwise go to IDLE.
- Complete pulses seen outside WAIT are ignored.
- error stays set until reset. It does not block later pointers.
- launch__rom__optionPtr and the descriptor outputs hold their last values between operations.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state IDLE, FIFO empty, ptr_ready=1
  - optionPtr=0, all descriptor outputs 0
  - valid=0, done=0, error=0, busy=0, lane flags 0
- Reset asserted mid-operation drops valid immediately and discards the queued pointers.
- Accepting edge at end of cycle N with FSM idle and FIFO otherwise empty:
  - optionPtr updates at end of N+1
  - descriptor is captured at end of N+1+ROM_WAIT
  - launch__stOp__valid first high in cycle N+2+ROM_WAIT (N+3 by default)
- Handshake at end of cycle H, both completes in cycle C>H: done is high in cycle C+2.
- Back-to-back pointers: the second pointer's optionPtr updates at the end of the first pointer's done cycle. No extra IDLE cycle.
- Throughput: at most one outstanding descriptor at the streaming-op controller.

## Test plan
- Single pointer 0x05, ROM op=0x11, nops=16, ready tied 1, completes 4 cycles later -> valid high cycle N+3 with descriptor equal to ROM entry 5; exactly one done pulse; busy low after done.
- Backpressure: ready low for 10 cycles -> valid stays high and descriptor stable throughout; a single handshake; no duplicate issue.
- Queue full: push 0x01, 0x02, 0x03 on consecutive cycles while first op stalls -> ptr_ready=0 on the third; 0x03 not taken; 0x01 then 0x02 launched in order.
- Completion ordering: complete1 before complete0, then both in the same cycle on the next op, plus a stray complete0 in IDLE -> done only after both per op; the stray pulse has no effect.
- Zero operands: ROM entry 0x07 has nops=0 -> no valid; done pulse; error=1; following pointer 0x08 launches normally with error still 1.
- Reset mid-ISSUE with one pointer queued -> valid drops immediately; after release, all outputs at reset values, ptr_ready=1, nothing launches.
